// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC/OldPC/IR with req/ack instruction read and timeout
module instr_fetch_unit #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            fetch_busy,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;

  // Next-state and register updates; pc_write beats fetch_start in IDLE, ack beats timeout in REQ
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    instr_d  = instr_q;
    timer_d  = timer_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_write) begin
          pc_d = pc_next;
        end else if (fetch_start) begin
          if (pc_q[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            timer_d = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          instr_d  = mem_rdata;
          old_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      instr_q  <= instr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = mem_req ? pc_q : '0;
  assign fetch_busy = (state_q != S_IDLE);
  assign fetch_done = (state_q == S_DONE);
  assign fetch_err  = err_q;
  assign pc         = pc_q;
  assign old_pc     = old_pc_q;
  assign instr      = instr_q;

endmodule
